// File: rtl/ofdm_tx_map.sv
// ofdm_tx_map: QPSK/pilot mapper that writes one 1024-bin Hermitian-symmetric
// OFDM symbol into the FFT BSRAM, one bin per cycle, ready for an IFFT pass.
module ofdm_tx_map #(
  parameter int                 DATA_BIN0 = 8,
  parameter int                 PILOT_BIN = 4,
  parameter logic signed [15:0] AMP       = 16'sd4096,
  parameter logic [10:0]        BASE_ADDR = 11'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        clear,
  input  logic [95:0] data,
  output logic        busy,
  output logic        finish,
  output logic        oce,
  output logic        ce,
  output logic        wre,
  output logic [10:0] ad,
  output logic [31:0] din
);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t             state, state_n;
  logic [9:0]         k, k_n;
  logic [95:0]        data_q, data_n;
  logic               busy_n, finish_n, ce_n, wre_n;
  logic [10:0]        ad_n;
  logic [31:0]        din_n;

  logic signed [15:0] amp_pos, amp_neg;
  logic signed [15:0] bin_re, bin_im;
  logic [6:0]         bit_idx;
  int                 kk;

  assign oce     = 1'b0;
  assign amp_pos = AMP;
  assign amp_neg = -AMP;

  // Frequency-domain value of bin k: pilot and its conjugate, data carriers
  // and their conjugate mirror; DC, Nyquist and unused bins are zero.
  always_comb begin
    bin_re  = '0;
    bin_im  = '0;
    bit_idx = '0;
    kk      = int'(k);
    if (kk == PILOT_BIN || kk == 1024 - PILOT_BIN) begin
      bin_re = amp_pos;
    end else if (kk >= DATA_BIN0 && kk <= DATA_BIN0 + 47) begin
      bit_idx = 7'(2 * (kk - DATA_BIN0));
      bin_re  = data_q[bit_idx]         ? amp_neg : amp_pos;
      bin_im  = data_q[bit_idx + 7'd1]  ? amp_neg : amp_pos;
    end else if (kk >= 1024 - DATA_BIN0 - 47 && kk <= 1024 - DATA_BIN0) begin
      bit_idx = 7'(2 * (1024 - DATA_BIN0 - kk));
      bin_re  = data_q[bit_idx]         ? amp_neg : amp_pos;
      bin_im  = data_q[bit_idx + 7'd1]  ? amp_pos : amp_neg;
    end
  end

  // Next-state and next-output logic; clear overrides everything else.
  always_comb begin
    state_n  = state;
    k_n      = k;
    data_n   = data_q;
    busy_n   = busy;
    finish_n = 1'b0;
    ce_n     = 1'b0;
    wre_n    = 1'b0;
    ad_n     = ad;
    din_n    = din;
    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start && !clear) begin
          data_n  = data;
          k_n     = '0;
          busy_n  = 1'b1;
          state_n = WRITE;
        end
      end
      WRITE: begin
        ce_n  = 1'b1;
        wre_n = 1'b1;
        ad_n  = BASE_ADDR + {1'b0, k};
        din_n = {bin_re, bin_im};
        k_n   = k + 10'd1;
        if (k == 10'd1023) state_n = DONE;
      end
      DONE: begin
        finish_n = 1'b1;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (clear) begin
      state_n  = IDLE;
      ce_n     = 1'b0;
      wre_n    = 1'b0;
      finish_n = 1'b0;
      busy_n   = 1'b0;
    end
  end

  // State and registered BSRAM-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      k      <= '0;
      data_q <= '0;
      busy   <= 1'b0;
      finish <= 1'b0;
      ce     <= 1'b0;
      wre    <= 1'b0;
      ad     <= '0;
      din    <= '0;
    end else begin
      state  <= state_n;
      k      <= k_n;
      data_q <= data_n;
      busy   <= busy_n;
      finish <= finish_n;
      ce     <= ce_n;
      wre    <= wre_n;
      ad     <= ad_n;
      din    <= din_n;
    end
  end

endmodule

// File: tb/tb_ofdm_tx_map.sv
// Directed bench for ofdm_tx_map with a BSRAM model capturing every write.
module tb_ofdm_tx_map;

  logic        clk = 1'b0;
  logic        rst_n, start, clear;
  logic [95:0] data;
  logic        busy, finish, oce, ce, wre;
  logic [10:0] ad;
  logic [31:0] din;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem     [2048];
  int          mem_gen [2048];
  int          cur_gen = 0;
  int          wr_cnt  = 0;
  int          oob_cnt = 0;

  ofdm_tx_map #(
    .DATA_BIN0 (8),
    .PILOT_BIN (4),
    .AMP       (16'sd4096),
    .BASE_ADDR (11'd0)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .clear  (clear),
    .data   (data),
    .busy   (busy),
    .finish (finish),
    .oce    (oce),
    .ce     (ce),
    .wre    (wre),
    .ad     (ad),
    .din    (din)
  );

  always #5 clk = ~clk;

  // BSRAM write port model
  always @(posedge clk) begin
    if (ce && wre) begin
      mem[ad]     <= din;
      mem_gen[ad] <= cur_gen;
      wr_cnt      <= wr_cnt + 1;
      if (ad >= 11'd1024) oob_cnt <= oob_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected bin contents written out in the hex each QPSK symbol maps to.
  function automatic logic [31:0] exp_bin(input int k, input logic [95:0] d);
    int i;
    logic [1:0] b;
    if (k == 4 || k == 1020) return 32'h1000_0000;
    if (k >= 8 && k <= 55) begin
      i = k - 8;
      b = {d[2*i+1], d[2*i]};
      case (b)
        2'b00:   return 32'h1000_1000;
        2'b01:   return 32'hF000_1000;
        2'b10:   return 32'h1000_F000;
        default: return 32'hF000_F000;
      endcase
    end
    if (k >= 969 && k <= 1016) begin
      i = 1016 - k;
      b = {d[2*i+1], d[2*i]};
      case (b)
        2'b00:   return 32'h1000_F000;
        2'b01:   return 32'hF000_F000;
        2'b10:   return 32'h1000_1000;
        default: return 32'hF000_1000;
      endcase
    end
    return 32'h0;
  endfunction

  // Bins below 'upto' must hold the expected value from this run; the rest
  // must not have been written in this run.
  task automatic check_bins(input string tag, input logic [95:0] d, input int upto);
    int bad = 0;
    for (int k = 0; k < 1024; k++) begin
      if (k < upto) begin
        if (mem_gen[k] != cur_gen || mem[k] !== exp_bin(k, d)) bad++;
      end else begin
        if (mem_gen[k] == cur_gen) bad++;
      end
    end
    check(tag, 64'(bad), 64'd0);
  endtask

  // ev_kind: 0 plain, 1 second start at cycle ev_cyc, 2 clear at ev_cyc,
  // 3 reset at ev_cyc.
  task automatic run_symbol(input logic [95:0] d, input int ev_kind, input int ev_cyc,
                            output int lat, output int nfin, output int nwr, output int noob);
    int w0, o0;
    lat  = -1;
    nfin = 0;
    cur_gen++;
    w0 = wr_cnt;
    o0 = oob_cnt;
    @(negedge clk);
    data  = d;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 1100; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (n == 1) begin
        check("first_ce", 64'({ce, wre, busy}), 64'b111);
        check("first_ad", 64'(ad), 64'd0);
      end
      if (n == 1024 && ev_kind < 2) check("last_ad", 64'(ad), 64'd1023);
      if (finish) begin
        nfin++;
        if (lat < 0) begin
          lat = n;
          check("fin_ce_busy", 64'({ce, wre, busy}), 64'b000);
        end
      end
      if (ev_kind == 1 && n == ev_cyc) begin
        start = 1'b1;
        data  = ~d;
      end
      if (ev_kind == 2 && n == ev_cyc) clear = 1'b1;
      if (ev_kind == 2 && n == ev_cyc + 1) begin
        clear = 1'b0;
        check("clear_outs", 64'({ce, wre, busy, finish}), 64'b0000);
      end
      if (ev_kind == 3 && n == ev_cyc) begin
        rst_n = 1'b0;
        #1;
        check("rst_ctl", 64'({ce, wre, busy, finish}), 64'b0000);
        check("rst_bus", 64'({ad, din}), 64'd0);
        #1 rst_n = 1'b1;
        break;
      end
      if (lat > 0 && n >= lat + 4) break;
    end
    @(posedge clk);
    #1;
    nwr  = wr_cnt - w0;
    noob = oob_cnt - o0;
  endtask

  int lat, nfin, nwr, noob;
  logic [95:0] d;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctl", 64'({busy, finish, ce, wre, oce}), 64'b00000);
    check("reset_bus", 64'({ad, din}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // all-zero payload
    d = '0;
    run_symbol(d, 0, 0, lat, nfin, nwr, noob);
    check("z_latency", 64'(lat), 64'd1025);
    check("z_nfin", 64'(nfin), 64'd1);
    check("z_writes", 64'(nwr), 64'd1024);
    check("z_oob", 64'(noob), 64'd0);
    check("z_bin8", 64'(mem[8]), 64'h1000_1000);
    check("z_bin55", 64'(mem[55]), 64'h1000_1000);
    check("z_bin969", 64'(mem[969]), 64'h1000_F000);
    check("z_bin1016", 64'(mem[1016]), 64'h1000_F000);
    check("z_bin4", 64'(mem[4]), 64'h1000_0000);
    check("z_bin1020", 64'(mem[1020]), 64'h1000_0000);
    check("z_bin0", 64'(mem[0]), 64'h0);
    check("z_bin512", 64'(mem[512]), 64'h0);
    check("z_bin56", 64'(mem[56]), 64'h0);
    check_bins("z_all", d, 1024);

    // all-ones payload
    d = '1;
    run_symbol(d, 0, 0, lat, nfin, nwr, noob);
    check("o_latency", 64'(lat), 64'd1025);
    check("o_bin8", 64'(mem[8]), 64'hF000_F000);
    check("o_bin55", 64'(mem[55]), 64'hF000_F000);
    check("o_bin969", 64'(mem[969]), 64'hF000_1000);
    check("o_bin1016", 64'(mem[1016]), 64'hF000_1000);
    check_bins("o_all", d, 1024);

    // carrier0 = (b0=0,b1=1), carrier1 = (b0=1,b1=0)
    d = 96'h6;
    run_symbol(d, 0, 0, lat, nfin, nwr, noob);
    check("s_bin8", 64'(mem[8]), 64'h1000_F000);
    check("s_bin9", 64'(mem[9]), 64'hF000_1000);
    check("s_bin1016", 64'(mem[1016]), 64'h1000_1000);
    check("s_bin1015", 64'(mem[1015]), 64'hF000_F000);
    check_bins("s_all", d, 1024);

    // start while busy is ignored
    d = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
    run_symbol(d, 1, 500, lat, nfin, nwr, noob);
    check("b_latency", 64'(lat), 64'd1025);
    check("b_nfin", 64'(nfin), 64'd1);
    check("b_writes", 64'(nwr), 64'd1024);
    check_bins("b_all", d, 1024);

    // clear at cycle 300: bins 0..299 written, nothing after, no finish
    d = 96'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3;
    run_symbol(d, 2, 300, lat, nfin, nwr, noob);
    check("c_nfin", 64'(nfin), 64'd0);
    check("c_writes", 64'(nwr), 64'd300);
    check("c_busy", 64'({busy, ce, wre}), 64'b000);
    check_bins("c_part", d, 300);
    d = 96'h5;
    run_symbol(d, 0, 0, lat, nfin, nwr, noob);
    check("c2_latency", 64'(lat), 64'd1025);
    check("c2_nfin", 64'(nfin), 64'd1);
    check_bins("c2_all", d, 1024);

    // async reset mid-write, then a clean symbol
    d = 96'hDEAD_BEEF_CAFE_F00D_1234_5678;
    run_symbol(d, 3, 700, lat, nfin, nwr, noob);
    check("r_nfin", 64'(nfin), 64'd0);
    check("r_idle", 64'({busy, ce, wre}), 64'b000);
    d = 96'h8000_0000_0000_0000_0000_0001;
    run_symbol(d, 0, 0, lat, nfin, nwr, noob);
    check("r2_latency", 64'(lat), 64'd1025);
    check("r2_bin8", 64'(mem[8]), 64'hF000_1000);
    check("r2_bin55", 64'(mem[55]), 64'h1000_F000);
    check_bins("r2_all", d, 1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
